ds_rr_arbiter: RTL
==================

Name: ds_rr_arbiter

Overview:
- Round-robin arbiter that shares one outbound DataStream between CHANNELS inbound DataStream requesters.
- Typical use: feeding a single downstream width divider or serialiser from several producers.
- Grants one channel at a time and holds the grant for a burst of up to BURST words.
- Zero-latency pass-through of the granted channel; reports the source channel of each outbound word.

Parameters:
- CHANNELS, 4, number of inbound requesters (>= 1).
- DWIDTH, 16, data width of every stream.
- BURST, 8, maximum words transferred per grant before arbitration is forced (>= 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset; one clock, no other reset.
- i_dat  input  CHANNELS*DWIDTH  inbound data; channel k occupies bits [k*DWIDTH +: DWIDTH].
- i_val  input  CHANNELS  inbound valid, one bit per channel.
- i_rdy  output  CHANNELS  inbound ready, one bit per channel.
- o_dat  output  DWIDTH  outbound data.
- o_val  output  1  outbound valid.
- o_rdy  input  1  outbound ready.
- o_chn  output  max(1,$clog2(CHANNELS))  index of the channel driving o_dat.

Behaviour:
- Transfer rule: a transfer occurs on a cycle where val & rdy are both high, on either side.
- Registered state:
  - state: IDLE or GRANT.
  - gnt: granted channel index.
  - last: last granted index.
  - cnt: words transferred in the current grant, range 0..BURST-1.
- Reset values: state=IDLE, gnt=0, last=CHANNELS-1 (so channel 0 has first priority), cnt=0.
- Outputs during reset and in IDLE: o_val=0, i_rdy all 0, o_dat=0, o_chn=0.
- IDLE:
  - If any i_val bit is high, choose the first channel with i_val high, searching cyclically from last+1.
  - Next cycle: gnt=chosen, last=chosen, cnt=0, state=GRANT.
  - If no i_val bit is high, stay in IDLE.
  - Arbitration decisions use only the current cycle's i_val.
- GRANT, combinational outputs:
  - o_dat = i_dat of channel gnt.
  - o_val = i_val[gnt].
  - o_chn = gnt.
  - i_rdy[gnt] = o_rdy; all other i_rdy bits are 0.
- GRANT, transitions:
  - Transfer with cnt==BURST-1: state goes to IDLE and cnt to 0 (burst exhausted).
  - Transfer with cnt<BURST-1: cnt increments and state stays GRANT.
  - i_val[gnt]==0: state goes to IDLE and cnt to 0 (requester went quiet). This is safe because o_val=0, so no word is pending.
  - o_val=1 with o_rdy=0: hold everything. The grant never changes while a word is stalled, so o_dat and o_chn stay stable until accepted.
- Latency and throughput:
  - First word is transferable one cycle after i_val rises in IDLE.
  - Each grant boundary costs exactly one IDLE bubble cycle.
  - Sustained throughput per grant is one word per cycle.
- Fairness: after a grant of channel k, channel k has the lowest priority at the next arbitration. Any continuously requesting channel is granted within CHANNELS arbitrations.
- Boundary cases:
  - BURST=1: every transfer returns to IDLE, giving alternating word and bubble cycles.
  - CHANNELS=1: o_chn is constantly 0, and the same channel is re-granted after each IDLE bubble.
  - A non-granted channel dropping or raising i_val during GRANT has no effect until the next IDLE.
  - Reset asserted mid-burst: grant is aborted immediately, all outputs go to their reset values, and no partial state survives.
- No combinational path from i_val of a non-granted channel to any output.

Test Plan:
- Reset, then i_val=4'b0001 with o_rdy=1 held. Required: IDLE for 1 cycle; then 8 consecutive words with o_chn=0; a 1-cycle bubble; then channel 0 re-granted.
- i_val=4'b1111, o_rdy=1, BURST=8. Required grant order 0,1,2,3,0; each grant carries 8 words; o_chn matches the source; one bubble between grants; no word lost or duplicated (check data sequence numbers per channel).
- Channel 2 granted, o_rdy held low 5 cycles mid-burst while channel 1 raises i_val. Required: o_dat, o_val and o_chn=2 stable for all 5 cycles; i_rdy[1]=0; cnt unchanged; burst resumes when o_rdy=1.
- Channel 0 granted, drops i_val after 3 words, channel 3 requesting. Required: return to IDLE; next grant is channel 3 (not channel 0) with cnt restarting at 0.
- reset_n pulsed low asynchronously at word 4 of a burst. Required: o_val and all i_rdy go to 0 immediately; after release, the first grant goes to the lowest requesting index (channel 0 priority).
- BURST=1, CHANNELS=2, both requesting, o_rdy=1. Required output pattern: word(ch0), bubble, word(ch1), bubble, repeating.

Source files
------------

// File: rtl/ds_rr_arbiter.sv
// rtl/ds_rr_arbiter.sv - round-robin arbiter sharing one outbound DataStream between CHANNELS requesters
//
// Grants one inbound channel at a time and passes it straight through to the
// outbound stream for a burst of up to BURST words. Each grant boundary costs
// one IDLE cycle, which is where the next channel is chosen.
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   reset_n  asynchronous active-low reset
//   i_dat    inbound data, channel k at [k*DWIDTH +: DWIDTH]
//   i_val    inbound valid, one bit per channel
//   i_rdy    inbound ready, only the granted channel can see o_rdy
//   o_dat    outbound data (zero while idle)
//   o_val    outbound valid
//   o_rdy    outbound ready
//   o_chn    index of the channel currently driving o_dat

module ds_rr_arbiter #(
   parameter int CHANNELS = 4,
   parameter int DWIDTH   = 16,
   parameter int BURST    = 8,
   localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int BW      = (BURST > 1) ? $clog2(BURST) : 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [CHANNELS*DWIDTH-1:0]   i_dat,
   input  logic [CHANNELS-1:0]          i_val,
   output logic [CHANNELS-1:0]          i_rdy,
   output logic [DWIDTH-1:0]            o_dat,
   output logic                         o_val,
   input  logic                         o_rdy,
   output logic [CW-1:0]                o_chn
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   logic [0:0]    state;
   logic [CW-1:0] gnt;
   logic [CW-1:0] last;
   logic [BW-1:0] cnt;

   logic [CW-1:0] pick;
   logic          xfer;
   logic          burst_end;

   // (base + off) modulo CHANNELS, off in 1..CHANNELS
   function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= CHANNELS) s = s - CHANNELS;
      return CW'(s);
   endfunction

   // Cyclic search starting just after the last grant, so the channel that
   // was served most recently is considered last.
   always_comb begin
      logic found;
      logic [CW-1:0] cand;
      pick  = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 1; i <= CHANNELS; i++) begin
         cand = wrap_idx(last, i);
         if (!found && i_val[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Pass-through of the granted channel only; non-granted valids never
   // reach an output.
   always_comb begin
      o_dat = '0;
      o_val = 1'b0;
      o_chn = '0;
      i_rdy = '0;
      if (state == ST_GRANT) begin
         o_dat      = i_dat[gnt*DWIDTH +: DWIDTH];
         o_val      = i_val[gnt];
         o_chn      = gnt;
         i_rdy[gnt] = o_rdy;
      end
   end

   assign xfer      = o_val & o_rdy;
   assign burst_end = (cnt == BW'(BURST - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         gnt   <= '0;
         last  <= CW'(CHANNELS - 1);
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|i_val) begin
                  gnt   <= pick;
                  last  <= pick;
                  cnt   <= '0;
                  state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               // Dropping valid is safe to act on: with o_val low nothing is
               // pending. A stalled word (o_val & !o_rdy) holds everything.
               if (!i_val[gnt]) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (xfer) begin
                  if (burst_end) begin
                     state <= ST_IDLE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
